// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
//
// Contents:
//   REG_ADDR_W   - architectural register index width.
//   CNT_W        - width of the shared INIT / MEM_WAIT cycle counter.
//   fwd_sel_t    - EX-stage ALU operand source select.
//   ctrl_state_t - controller sequencing state.
//   fwd_hit()    - true when a later-stage write targets the given source register.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        INIT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10
    } ctrl_state_t;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  we,
                                     input logic [REG_ADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage forwarding select for one ALU operand. Purely combinational.
//
// Ports:
//   i_rs_e         - EX-stage source register of this operand
//   i_rd_m         - MEM-stage destination register
//   i_reg_write_m  - MEM-stage instruction writes the register file
//   i_rd_w         - WB-stage destination register
//   i_reg_write_w  - WB-stage instruction writes the register file
//   o_fwd          - operand source: FWD_REG, FWD_WB or FWD_MEM
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_w,
    output fwd_sel_t              o_fwd
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        if (fwd_hit(i_rd_m, i_reg_write_m, i_rs_e)) begin
            o_fwd = FWD_MEM;
        end else if (fwd_hit(i_rd_w, i_reg_write_w, i_rs_e)) begin
            o_fwd = FWD_WB;
        end else begin
            o_fwd = FWD_REG;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Drives stall/flush of the pipeline registers and the EX forwarding selects,
// holds the pipe flushed for INIT_CYCLES after reset, and freezes it while
// data memory is busy. All stall/flush/forward outputs are combinational from
// the state and current inputs; o_mem_timeout is a sticky register.
//
// Optional build macro: PIPE_PERF_EN adds three 32-bit performance counters.
//
// Ports:
//   i_clk, i_rst                 - clock (rising edge), async active-high reset
//   i_rs1_d, i_rs2_d             - ID-stage source registers
//   i_rs1_e, i_rs2_e, i_rd_e     - EX-stage sources and destination
//   i_mem_read_e                 - EX instruction is a load
//   i_pcsrc_e                    - branch/jump taken, resolved in EX
//   i_rd_m, i_reg_write_m        - MEM-stage destination and write enable
//   i_mem_req_m, i_mem_ready_m   - data memory request / completion
//   i_rd_w, i_reg_write_w        - WB-stage destination and write enable
//   o_stall_f/d/e/m              - hold PC, IF_ID, ID_EX, EX_MEM
//   o_flush_d/e/m/w              - clear IF_ID, ID_EX, EX_MEM, MEM_WB
//   o_forward_a_e, o_forward_b_e - ALU operand selects (00 reg, 01 WB, 10 MEM)
//   o_perf_*_cnt                 - (PIPE_PERF_EN) load-use, branch-flush, mem-wait counts
//   o_mem_timeout                - sticky: memory wait exceeded MEM_TIMEOUT
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_rs1_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_d,
    input  logic [REG_ADDR_W-1:0] i_rs1_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_e,
    input  logic [REG_ADDR_W-1:0] i_rd_e,
    input  logic                  i_mem_read_e,
    input  logic                  i_pcsrc_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    input  logic                  i_mem_req_m,
    input  logic                  i_mem_ready_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_w,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_stall_m,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic                  o_flush_m,
    output logic                  o_flush_w,
    output logic [1:0]            o_forward_a_e,
    output logic [1:0]            o_forward_b_e,
`ifdef PIPE_PERF_EN
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_flush_cnt,
    output logic [31:0]           o_perf_memwait_cnt,
`endif
    output logic                  o_mem_timeout
);

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    ctrl_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic             w_hold;
    logic             w_load_use;
    logic [CNT_W-1:0] w_cnt_inc;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;

    assign w_load_use = i_mem_read_e && (i_rd_e != '0) &&
                        ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

    // In RUN a pending access freezes the pipe; once in MEM_WAIT only
    // mem_ready matters, and it releases the stall in the same cycle.
    assign w_hold = (r_state == MEM_WAIT) ? !i_mem_ready_m
                                          : (i_mem_req_m && !i_mem_ready_m);

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= INIT;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (w_hold) begin
                        r_state <= MEM_WAIT;
                        r_cnt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (i_mem_ready_m) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TIMEOUT_CNT) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_stall_f = 1'b0;
        o_stall_d = 1'b0;
        o_stall_e = 1'b0;
        o_stall_m = 1'b0;
        o_flush_d = 1'b0;
        o_flush_e = 1'b0;
        o_flush_m = 1'b0;
        o_flush_w = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_hold) begin
                    // Freeze everything up to EX_MEM; bubble into MEM_WB.
                    o_stall_f = 1'b1;
                    o_stall_d = 1'b1;
                    o_stall_e = 1'b1;
                    o_stall_m = 1'b1;
                    o_flush_w = 1'b1;
                end else if (i_pcsrc_e) begin
                    // A load-use hazard here is on the wrong path and is dropped.
                    o_flush_d = 1'b1;
                    o_flush_e = 1'b1;
                end else if (w_load_use) begin
                    o_stall_f = 1'b1;
                    o_stall_d = 1'b1;
                    o_flush_e = 1'b1;
                end
            end
            default: begin
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
                o_flush_m = 1'b1;
                o_flush_w = 1'b1;
            end
        endcase
    end

    forward_unit u_fwd_a (
        .i_rs_e        (i_rs1_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_fwd         (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .i_rs_e        (i_rs2_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_fwd         (w_fwd_b)
    );

    assign o_forward_a_e = w_fwd_a;
    assign o_forward_b_e = w_fwd_b;
    assign o_mem_timeout = r_timeout;

`ifdef PIPE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_memwait;

    // Load-use is the only case stalling IF_ID without EX_MEM; branch flush is
    // the only case flushing IF_ID without EX_MEM (INIT flushes all four).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
            r_perf_memwait <= '0;
        end else begin
            if (o_stall_d && !o_stall_m) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (o_flush_d && !o_flush_m) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (o_stall_m) begin
                r_perf_memwait <= r_perf_memwait + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt   = r_perf_stall;
    assign o_perf_flush_cnt   = r_perf_flush;
    assign o_perf_memwait_cnt = r_perf_memwait;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table of RUN-state hazard/forwarding
// vectors plus hand-written reset, INIT, memory-wait and timeout sequences.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       mem_read_e, pcsrc_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_timeout;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_memwait;
`endif

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(
        .INIT_CYCLES (2),
        .MEM_TIMEOUT (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rs1_d       (rs1_d),
        .i_rs2_d       (rs2_d),
        .i_rs1_e       (rs1_e),
        .i_rs2_e       (rs2_e),
        .i_rd_e        (rd_e),
        .i_mem_read_e  (mem_read_e),
        .i_pcsrc_e     (pcsrc_e),
        .i_rd_m        (rd_m),
        .i_reg_write_m (reg_write_m),
        .i_mem_req_m   (mem_req_m),
        .i_mem_ready_m (mem_ready_m),
        .i_rd_w        (rd_w),
        .i_reg_write_w (reg_write_w),
        .o_stall_f     (stall_f),
        .o_stall_d     (stall_d),
        .o_stall_e     (stall_e),
        .o_stall_m     (stall_m),
        .o_flush_d     (flush_d),
        .o_flush_e     (flush_e),
        .o_flush_m     (flush_m),
        .o_flush_w     (flush_w),
        .o_forward_a_e (fwd_a),
        .o_forward_b_e (fwd_b),
`ifdef PIPE_PERF_EN
        .o_perf_stall_cnt   (perf_stall),
        .o_perf_flush_cnt   (perf_flush),
        .o_perf_memwait_cnt (perf_memwait),
`endif
        .o_mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1_d;
        logic [4:0] rs2_d;
        logic [4:0] rd_e;
        logic       mem_read_e;
        logic       pcsrc_e;
        logic [4:0] rs1_e;
        logic [4:0] rs2_e;
        logic [4:0] rd_m;
        logic       reg_write_m;
        logic [4:0] rd_w;
        logic       reg_write_w;
        logic [3:0] exp_stall;   // {f, d, e, m}
        logic [3:0] exp_flush;   // {d, e, m, w}
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] es, input logic [3:0] ef,
                           input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, " stall"}, 32'({stall_f, stall_d, stall_e, stall_m}), 32'(es));
        chk({tag, " flush"}, 32'({flush_d, flush_e, flush_m, flush_w}), 32'(ef));
        chk({tag, " fwd_a"}, 32'(fwd_a), 32'(fa));
        chk({tag, " fwd_b"}, 32'(fwd_b), 32'(fb));
    endtask

    task automatic idle_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        mem_read_e = 1'b0; pcsrc_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    // Each call starts a new cycle: inputs change at the falling edge and are
    // checked 1 ns later, well clear of the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        // rs1_d rs2_d rd_e mr pc rs1_e rs2_e rd_m wm rd_w ww stall flush fa fb
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b1100, 4'b0100, 2'b00, 2'b00});
        // Hazard gone next cycle: no lingering stall.
        vecs.push_back('{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b1100, 4'b0100, 2'b00, 2'b00});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b1100, 2'b00, 2'b00});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                         4'b0000, 4'b1100, 2'b00, 2'b00});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1,
                         4'b0000, 4'b0000, 2'b10, 2'b10});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1,
                         4'b0000, 4'b0000, 2'b01, 2'b01});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1,
                         4'b0000, 4'b0000, 2'b00, 2'b00});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd8, 5'd7, 1'b1, 5'd8, 1'b1,
                         4'b0000, 4'b0000, 2'b10, 2'b01});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd8, 5'd8, 1'b1, 5'd7, 1'b0,
                         4'b0000, 4'b0000, 2'b00, 2'b10});
        vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd3, 5'd4, 1'b1, 5'd9, 1'b1,
                         4'b0000, 4'b0000, 2'b01, 2'b00});

        // Reset state.
        idle_inputs();
        rst = 1'b1;
        #12;
        chk_out("reset", 4'b0000, 4'b1111, 2'b00, 2'b00);
        chk("reset timeout", 32'(mem_timeout), 32'd0);

        // INIT: two flushed cycles after release; memory busy is ignored,
        // forwarding still works.
        next_cycle();
        rst = 1'b0;
        mem_req_m = 1'b1;
        #1 chk_out("init0", 4'b0000, 4'b1111, 2'b00, 2'b00);
        next_cycle();
        rs1_e = 5'd3; rd_m = 5'd3; reg_write_m = 1'b1;
        #1 chk_out("init1", 4'b0000, 4'b1111, 2'b10, 2'b00);
        next_cycle();
        idle_inputs();
        #1 chk_out("run0", 4'b0000, 4'b0000, 2'b00, 2'b00);

        // Table of RUN-state vectors.
        foreach (vecs[i]) begin
            next_cycle();
            rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d; rd_e = vecs[i].rd_e;
            mem_read_e = vecs[i].mem_read_e; pcsrc_e = vecs[i].pcsrc_e;
            rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
            rd_m = vecs[i].rd_m; reg_write_m = vecs[i].reg_write_m;
            rd_w = vecs[i].rd_w; reg_write_w = vecs[i].reg_write_w;
            #1 chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush,
                       vecs[i].exp_fa, vecs[i].exp_fb);
        end

        // Memory wait for 3 cycles with a frozen taken branch, serviced on release.
        next_cycle();
        idle_inputs();
        mem_req_m = 1'b1; pcsrc_e = 1'b1;
        #1 chk_out("mw busy0", 4'b1111, 4'b0001, 2'b00, 2'b00);
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            mem_req_m = (c == 1);  // request may drop; only ready ends the wait
            #1 chk_out($sformatf("mw busy%0d", c), 4'b1111, 4'b0001, 2'b00, 2'b00);
        end
        next_cycle();
        mem_ready_m = 1'b1;
        #1 chk_out("mw release", 4'b0000, 4'b1100, 2'b00, 2'b00);
        next_cycle();
        idle_inputs();
        #1 chk_out("mw back run", 4'b0000, 4'b0000, 2'b00, 2'b00);
        chk("mw no timeout", 32'(mem_timeout), 32'd0);

        // Release cycle with a load-use hazard stalls for it.
        next_cycle();
        mem_req_m = 1'b1;
        #1 chk_out("mw2 busy", 4'b1111, 4'b0001, 2'b00, 2'b00);
        next_cycle();
        mem_ready_m = 1'b1; mem_read_e = 1'b1; rd_e = 5'd4; rs2_d = 5'd4;
        #1 chk_out("mw2 release lu", 4'b1100, 4'b0100, 2'b00, 2'b00);
        next_cycle();
        idle_inputs();
        #1 chk_out("mw2 back run", 4'b0000, 4'b0000, 2'b00, 2'b00);

        // Timeout: RUN busy cycle, then 4 MEM_WAIT cycles before the flag rises.
        next_cycle();
        mem_req_m = 1'b1;
        #1 chk("to run cycle", 32'(mem_timeout), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            #1 chk($sformatf("to wait%0d", c), 32'(mem_timeout), 32'd0);
        end
        next_cycle();
        #1 chk("to raised", 32'(mem_timeout), 32'd1);
        chk_out("to still waiting", 4'b1111, 4'b0001, 2'b00, 2'b00);
        next_cycle();
        mem_ready_m = 1'b1;
        #1 chk_out("to release", 4'b0000, 4'b0000, 2'b00, 2'b00);
        next_cycle();
        idle_inputs();
        #1 chk("to sticky", 32'(mem_timeout), 32'd1);
        chk_out("to back run", 4'b0000, 4'b0000, 2'b00, 2'b00);
        next_cycle();
        rst = 1'b1;
        #1 chk("to cleared by rst", 32'(mem_timeout), 32'd0);

        // Reset asserted in the middle of a memory wait.
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        mem_req_m = 1'b1;
        #1 chk_out("rw busy", 4'b1111, 4'b0001, 2'b00, 2'b00);
        next_cycle();
        #1 chk_out("rw waiting", 4'b1111, 4'b0001, 2'b00, 2'b00);
        #2 rst = 1'b1;
        #1 chk_out("rw reset", 4'b0000, 4'b1111, 2'b00, 2'b00);
        next_cycle();
        rst = 1'b0;
        #1 chk_out("rw init0", 4'b0000, 4'b1111, 2'b00, 2'b00);
        next_cycle();
        #1 chk_out("rw init1", 4'b0000, 4'b1111, 2'b00, 2'b00);
        next_cycle();
        #1 chk_out("rw run busy", 4'b1111, 4'b0001, 2'b00, 2'b00);
        next_cycle();
        idle_inputs();
        mem_ready_m = 1'b1;
        #1 chk_out("rw release", 4'b0000, 4'b0000, 2'b00, 2'b00);

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64 pipeline. It drives the stall and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB registers, and the EX-stage forwarding selects. It also sequences pipeline start-up after reset and freezes the pipe while data memory is busy. One instance sits beside the pipeline registers in the core top level.

Parameters:
INIT_CYCLES, 2, cycles all pipeline registers are held flushed after reset deassertion (1..15)
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
rs1_d  in  5  ID-stage source register 1
rs2_d  in  5  ID-stage source register 2
rs1_e  in  5  EX-stage source register 1
rs2_e  in  5  EX-stage source register 2
rd_e  in  5  EX-stage destination
mem_read_e  in  1  EX instruction is a load
pcsrc_e  in  1  branch/jump taken, resolved in EX
rd_m  in  5  MEM-stage destination
reg_write_m  in  1  MEM instruction writes the register file
mem_req_m  in  1  MEM stage accessing data memory
mem_ready_m  in  1  data memory completes the access this cycle
rd_w  in  5  WB-stage destination
reg_write_w  in  1  WB instruction writes the register file
stall_f  out  1  hold PC
stall_d  out  1  hold IF_ID
stall_e  out  1  hold ID_EX
stall_m  out  1  hold EX_MEM
flush_d  out  1  clear IF_ID to bubble
flush_e  out  1  clear ID_EX to bubble
flush_m  out  1  clear EX_MEM to bubble
flush_w  out  1  clear MEM_WB to bubble
forward_a_e  out  2  ALU operand A select: 00 regfile, 01 WB result, 10 MEM result
forward_b_e  out  2  same for operand B
mem_timeout  out  1  sticky error: memory wait exceeded MEM_TIMEOUT

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=INIT, cycle counter=0, mem_timeout=0. All flush_* =1, all stall_* =0, forward_* =00.
- State register: INIT, RUN, MEM_WAIT. Counter is 8 bits, shared by INIT and MEM_WAIT, cleared on every state change.
- INIT: all flush_* =1, stalls 0. Leave for RUN after INIT_CYCLES edges following rst release. Inputs are ignored.
- RUN, evaluated in this priority order, all outputs combinational from the state and current inputs:
  1. Memory busy (mem_req_m & ~mem_ready_m): stall_f/d/e/m=1, flush_w=1, every other flush 0. Next state MEM_WAIT.
  2. Else branch taken (pcsrc_e): flush_d=1, flush_e=1, no stalls. A simultaneous load-use condition is discarded because it is on the wrong path.
  3. Else load-use (mem_read_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d)): stall_f=1, stall_d=1, flush_e=1. This lasts exactly one cycle.
  4. Else all stalls and flushes 0.
- MEM_WAIT:
  - Outputs are the same as RUN item 1 every cycle.
  - Counter increments and saturates at 255.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set. It is cleared only by rst.
  - When mem_ready_m=1: the stall is released in that same cycle (outputs as RUN items 2–4) and next state is RUN.
  - A pending pcsrc_e is held frozen in EX and is serviced in the release cycle.
  - The controller stays in MEM_WAIT after a timeout.
- Forwarding is independent of state, including INIT:
  - forward_a_e=10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - Else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - Else 00.
  - MEM has priority over WB. forward_b_e uses the same rules with rs2_e. Register x0 never forwards.
- rst asserted mid-MEM_WAIT or mid-stall: immediate return to INIT outputs, with no partial state retained.

Optional Feature:
PIPE_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0] and perf_memwait_cnt[31:0].
  - perf_stall_cnt increments on each RUN load-use stall cycle.
  - perf_flush_cnt increments on each branch-flush cycle.
  - perf_memwait_cnt increments on each cycle with stall_m=1.
  - All three reset to 0, wrap at 2^32, and do not count during INIT.
- Undefined: these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- pipeline_pkg holds:
  - REG_ADDR_W=5.
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - ctrl_state_t enum: INIT, RUN, MEM_WAIT.
- Sub-module forward_unit: purely combinational, one instance per operand (A, B). Inputs rs_e, rd_m, reg_write_m, rd_w, reg_write_w; output fwd_sel_t.

Test Plan:
- Reset release, INIT_CYCLES=2 → flush_d/e/m/w=1 for 2 cycles after rst falls, then all 0 with pcsrc_e=0 and no hazards.
- Load-use: mem_read_e=1, rd_e=5, rs1_d=5 → stall_f=stall_d=flush_e=1 for one cycle. The same case with rd_e=0 → no stall.
- Branch with load-use: pcsrc_e=1 together with the load-use above → flush_d=flush_e=1, stall_f=stall_d=0.
- Memory wait: mem_req_m=1, mem_ready_m=0 for 3 cycles, then 1 → stall_f/d/e/m=1 and flush_w=1 for 3 cycles, released in the ready cycle, state back to RUN.
- Timeout: MEM_TIMEOUT=4 and mem_ready_m held 0 → mem_timeout rises after 4 MEM_WAIT cycles and stays set after ready. rst clears it.
- Forwarding: rs1_e=rs2_e=7, rd_m=rd_w=7, both reg_write=1 → forward_a_e=forward_b_e=10. Then reg_write_m=0 → 01. rd_m=rd_w=0 → 00.
